mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory port between the pipeline's IF stage (instruction fetch, read-only) and MEM stage (data load/store).
//  Registers each granted request and holds it on the shared port until the memory acks.
//  Returns read data and a one-cycle ack to the winning requester.
//  Drives stall_if / stall_mem so the pipeline registers freeze while their stage waits.
// PARAMETERS
//  ADDR_W      64  address width (byte address, as PC and ALU result)
//  DATA_W      64  memory data width
//  STARVE_MAX  4   consecutive contended DM grants before IF is forced (only with ARB_STARVE_GUARD_EN)
// PORTS
//  clk        in   1       clock; all state changes on rising edge
//  reset      in   1       reset, asynchronous and active-low
//  if_req     in   1       IF requests a fetch; held until if_ack
//  if_addr    in   ADDR_W  fetch address (PC)
//  if_rdata   out  32      fetched instruction; valid when if_ack=1
//  if_ack     out  1       one-cycle pulse: fetch complete
//  dm_req     in   1       MEM stage requests access; held until dm_ack
//  dm_we      in   1       1=store, 0=load
//  dm_addr    in   ADDR_W  data address
//  dm_wdata   in   DATA_W  store data
//  dm_rdata   out  DATA_W  load data; valid when dm_ack=1
//  dm_ack     out  1       one-cycle pulse: data access complete
//  mem_req    out  1       request to shared memory; held until mem_ack
//  mem_we     out  1       write enable to memory
//  mem_addr   out  ADDR_W  registered address to memory
//  mem_wdata  out  DATA_W  registered write data to memory
//  mem_rdata  in   DATA_W  memory read data; sampled when mem_ack=1
//  mem_ack    in   1       memory completes current request (variable latency, >=0 wait)
//  stall_if   out  1       if_req & ~if_ack (combinational)
//  stall_mem  out  1       dm_req & ~dm_ack (combinational)
//  owner      out  1       0=IF, 1=DM; current/last grant
// BEHAVIOUR
//  - Reset (reset=0): state IDLE; all outputs 0; addr/wdata/rdata regs 0; starve count 0. Takes effect immediately and aborts any in-flight access without an ack.
//  - FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
//  - IDLE: if dm_req, then capture dm_addr/dm_wdata/dm_we, owner<=1, go to BUSY_DM.
//    Else if if_req, then capture if_addr with we=0, owner<=0, go to BUSY_IF. Else stay.
//  - DM wins when both requests are present (it holds the older instruction), except as noted under CONFIGURATION.
//  - BUSY_x: mem_req=1; mem_addr/mem_we/mem_wdata are stable from the captured regs.
//    On mem_ack, capture mem_rdata into the owner's rdata reg and go to RESP.
//  - RESP: mem_req=0; pulse the owner's ack for exactly one cycle; go to IDLE.
//    Both requests are ignored in RESP, so the requester deasserts req in the cycle after its ack.
//  - Latency: req sampled in IDLE at cycle N, mem_req high N+1..M, mem_ack at M, ack at M+1.
//    Minimum 3 cycles with zero-wait memory.
//  - if_rdata = captured mem_rdata[31:0]; dm_rdata = full DATA_W. Both hold their value until the next capture for that owner.
//  - mem_ack in IDLE or RESP is ignored: no state change, no ack.
//  - Requester dropping req while BUSY: the access still completes and the ack still pulses. Requests are never aborted except by reset.
//  - mem_rdata is ignored for stores; dm_rdata is still loaded with mem_rdata on store completion.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined:
//   - A counter increments on each DM grant taken while if_req=1; it clears on any IF grant.
//   - When the counter == STARVE_MAX and if_req=1, IDLE grants IF even if dm_req=1.
//  ARB_STARVE_GUARD_EN undefined: strict DM priority; no counter logic. IF may starve while dm_req is held.
// TESTING
//  1. dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xDEAD, mem_ack 2 cycles after mem_req rises
//     -> mem_we=1, mem_addr=0x40, mem_wdata=0xDEAD; dm_ack one pulse cycle after mem_ack; stall_mem high until then.
//  2. if_req=1, if_addr=0x10, zero-wait memory returns 0x00500093
//     -> if_ack at cycle 3, if_rdata=0x00500093, dm_ack stays 0.
//  3. if_req and dm_req rise the same cycle
//     -> DM served first (owner=1), RESP, IDLE, then IF served; stall_if high throughout.
//  4. Guard on, STARVE_MAX=2, dm_req and if_req held high -> grant order DM, DM, IF, DM, DM, IF.
//     Guard off -> IF never granted.
//  5. reset driven low while BUSY_DM with mem_req=1
//     -> mem_req, dm_ack, owner to 0 immediately; after release a new if_req completes normally.
//  6. mem_ack pulsed while IDLE with no requests -> no ack, state stays IDLE, mem_req stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch (IF) and data access (DM).
// Optional IF anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

  state_t state, state_nx;
  logic   grant_dm, grant_if, force_if;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 2);
  logic [CNT_W-1:0] starve_cnt;

  assign force_if = if_req && (starve_cnt == CNT_W'(STARVE_MAX));

  // Counts DM grants that left a pending fetch waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      starve_cnt <= '0;
    else if (grant_if)
      starve_cnt <= '0;
    else if (grant_dm && if_req)
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^STARVE_MAX;
  assign force_if   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_dm = 1'b0;
    grant_if = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && !force_if) begin
          grant_dm = 1'b1;
          state_nx = BUSY_DM;
        end else if (if_req) begin
          grant_if = 1'b1;
          state_nx = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: if (mem_ack) state_nx = RESP;
      RESP:             state_nx = IDLE;
      default:          state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      owner     <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if (grant_dm) begin
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_we    <= dm_we;
        owner     <= 1'b1;
      end else if (grant_if) begin
        mem_addr  <= if_addr;
        mem_we    <= 1'b0;
        owner     <= 1'b0;
      end
      if (mem_ack && state == BUSY_DM) dm_rdata <= mem_rdata;
      if (mem_ack && state == BUSY_IF) if_rdata <= mem_rdata[31:0];
    end
  end

  assign mem_req   = (state == BUSY_IF) || (state == BUSY_DM);
  assign if_ack    = (state == RESP) && !owner;
  assign dm_ack    = (state == RESP) && owner;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a variable-latency memory responder.
// Expectations for the starvation scenario follow ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_ack, dm_req, dm_we, dm_ack;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [31:0]   if_rdata;
  logic [DW-1:0] dm_wdata, dm_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack, stall_if, stall_mem, owner;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_dm; logic [63:0] data; } exp_t;
  exp_t sb[$];

  int          checks = 0;
  int          fails  = 0;
  int          mem_wait = 0;
  bit          mem_auto = 1'b1;
  logic [63:0] mem_base = '0;
  int          wcnt = 0;

  // Memory responder: acks after mem_wait cycles of mem_req, data = mem_base + address.
  always @(negedge clk) begin
    if (mem_auto) begin
      mem_ack   = 1'b0;
      mem_rdata = 64'hDEAD_BEEF_BAD0_BAD0;
      if (!reset || !mem_req) wcnt = 0;
      else if (wcnt == mem_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_base + mem_addr;
        wcnt      = 0;
      end else wcnt++;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_ack = 0; mem_rdata = '0;
    tick; tick;
    checks++;
    if ({mem_req, mem_we, if_ack, dm_ack, owner, stall_if, stall_mem} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl got %b want 0", {mem_req, mem_we, if_ack, dm_ack, owner, stall_if, stall_mem});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      fails++; $display("FAIL reset_bus got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    checks++;
    if (if_rdata !== '0 || dm_rdata !== '0) begin
      fails++; $display("FAIL reset_rdata got if=%h dm=%h want 0", if_rdata, dm_rdata);
    end
    reset = 1'b1;
    tick;
    checks++;
    if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_idle mem_req got %b want 0", mem_req); end
  endtask

  task automatic test_dm_store;
    exp_t e;
    int   cyc = 0, ack_cyc = -1;
    bit   got = 0, bad_bus = 0, bad_stall = 0;
    mem_wait = 2; mem_base = 64'h1111_2222_3333_0000;
    sb.push_back('{1'b1, mem_base + 64'h40});
    dm_we = 1; dm_addr = 64'h40; dm_wdata = 64'hDEAD; dm_req = 1;
    while (!got && cyc < 40) begin
      tick; cyc++;
      if (mem_req && (mem_we !== 1'b1 || mem_addr !== 64'h40 || mem_wdata !== 64'hDEAD)) bad_bus = 1;
      if (mem_ack) ack_cyc = cyc;
      if (!dm_ack && stall_mem !== 1'b1) bad_stall = 1;
      if (dm_ack) got = 1;
    end
    checks++;
    if (!got) begin fails++; $display("FAIL store_timeout got no dm_ack want ack"); sb.delete(); end
    else begin
      e = sb.pop_front();
      checks++;
      if (dm_rdata !== e.data || if_ack !== 1'b0 || owner !== 1'b1) begin
        fails++; $display("FAIL store_resp got rdata=%h if_ack=%b owner=%b want %h 0 1", dm_rdata, if_ack, owner, e.data);
      end
      checks++;
      if (stall_mem !== 1'b0) begin fails++; $display("FAIL store_stall_at_ack got %b want 0", stall_mem); end
    end
    checks++;
    if (bad_bus) begin fails++; $display("FAIL store_bus got mismatched bus want we=1 addr=40 wdata=dead"); end
    checks++;
    if (bad_stall) begin fails++; $display("FAIL store_stall got low before ack want high"); end
    checks++;
    if (cyc != 4 || ack_cyc != 3) begin fails++; $display("FAIL store_latency got ack=%0d mem_ack=%0d want 4 3", cyc, ack_cyc); end
    dm_req = 0; dm_we = 0;
    tick;
    checks++;
    if (dm_ack !== 1'b0 || mem_req !== 1'b0) begin
      fails++; $display("FAIL store_pulse got dm_ack=%b mem_req=%b want 0 0", dm_ack, mem_req);
    end
  endtask

  task automatic test_if_fetch;
    exp_t e;
    int   cyc = 0;
    bit   got = 0, bad_bus = 0, bad_dm = 0;
    mem_wait = 0; mem_base = 64'hFFFF_FFFF_0050_0093 - 64'h10;
    sb.push_back('{1'b0, 64'hFFFF_FFFF_0050_0093});
    if_addr = 64'h10; if_req = 1;
    while (!got && cyc < 40) begin
      tick; cyc++;
      if (mem_req && (mem_we !== 1'b0 || mem_addr !== 64'h10)) bad_bus = 1;
      if (dm_ack !== 1'b0) bad_dm = 1;
      if (if_ack) got = 1;
    end
    checks++;
    if (!got) begin fails++; $display("FAIL fetch_timeout got no if_ack want ack"); sb.delete(); end
    else begin
      e = sb.pop_front();
      checks++;
      if (if_rdata !== e.data[31:0] || owner !== 1'b0 || cyc != 2) begin
        fails++; $display("FAIL fetch_resp got rdata=%h owner=%b lat=%0d want %h 0 2", if_rdata, owner, cyc, e.data[31:0]);
      end
    end
    checks++;
    if (bad_bus || bad_dm) begin fails++; $display("FAIL fetch_bus got bus_err=%b dm_ack_seen=%b want 0 0", bad_bus, bad_dm); end
    if_req = 0;
    tick;
  endtask

  task automatic test_contention;
    exp_t        e;
    logic [63:0] obs, want;
    int          cyc = 0, acks = 0;
    int          ack_at[2];
    bit          bad_stall = 0;
    mem_wait = 1; mem_base = 64'h0A0A_0000_0000_0000;
    sb.push_back('{1'b1, mem_base + 64'h80});
    sb.push_back('{1'b0, mem_base + 64'h24});
    dm_we = 0; dm_addr = 64'h80; if_addr = 64'h24;
    dm_req = 1; if_req = 1;
    while (acks < 2 && cyc < 60) begin
      tick; cyc++;
      if (!if_ack && stall_if !== 1'b1) bad_stall = 1;
      if (if_ack || dm_ack) begin
        checks++;
        if (sb.size() == 0) begin fails++; $display("FAIL contention_sb got unexpected ack want none"); end
        else begin
          e    = sb.pop_front();
          obs  = dm_ack ? dm_rdata : {32'h0, if_rdata};
          want = e.is_dm ? e.data : {32'h0, e.data[31:0]};
          if ({dm_ack, if_ack, owner} !== {e.is_dm, !e.is_dm, e.is_dm} || obs !== want) begin
            fails++; $display("FAIL contention_ack got dm=%b if=%b owner=%b data=%h want dm=%b data=%h",
                              dm_ack, if_ack, owner, obs, e.is_dm, want);
          end
        end
        ack_at[acks] = cyc;
        acks++;
        if (dm_ack) dm_req = 0;
        if (if_ack) if_req = 0;
      end
    end
    checks++;
    if (acks != 2 || ack_at[0] != 3 || ack_at[1] != 7) begin
      fails++; $display("FAIL contention_timing got acks=%0d at %0d,%0d want 2 at 3,7", acks, ack_at[0], ack_at[1]);
    end
    checks++;
    if (bad_stall) begin fails++; $display("FAIL contention_stall_if got low before if_ack want high"); end
    dm_req = 0; if_req = 0; sb.delete();
    tick;
  endtask

  task automatic test_starve;
    exp_t        e;
    logic [63:0] obs, want;
    int          cyc = 0, acks = 0;
    bit [5:0]    order;
`ifdef ARB_STARVE_GUARD_EN
    order = 6'b011011;
`else
    order = 6'b111111;
`endif
    mem_wait = 0; mem_base = 64'h7700_0000_0000_0000;
    for (int unsigned i = 0; i < 6; i++)
      sb.push_back('{order[i], mem_base + (order[i] ? 64'h100 : 64'h200)});
    dm_we = 0; dm_addr = 64'h100; if_addr = 64'h200;
    dm_req = 1; if_req = 1;
    while (acks < 6 && cyc < 80) begin
      tick; cyc++;
      if (if_ack || dm_ack) begin
        checks++;
        e    = sb.pop_front();
        obs  = dm_ack ? dm_rdata : {32'h0, if_rdata};
        want = e.is_dm ? e.data : {32'h0, e.data[31:0]};
        if (dm_ack !== e.is_dm || obs !== want) begin
          fails++; $display("FAIL starve_grant%0d got dm_ack=%b data=%h want dm=%b data=%h", acks, dm_ack, obs, e.is_dm, want);
        end
        acks++;
      end
    end
    checks++;
    if (acks != 6) begin fails++; $display("FAIL starve_timeout got %0d acks want 6", acks); end
    dm_req = 0; if_req = 0; sb.delete();
    tick; tick;
  endtask

  task automatic test_reset_abort;
    exp_t e;
    int   cyc = 0;
    bit   got = 0, bad_dm = 0;
    mem_wait = 10;
    dm_we = 0; dm_addr = 64'h300; dm_req = 1;
    tick; tick;
    checks++;
    if (mem_req !== 1'b1 || owner !== 1'b1) begin
      fails++; $display("FAIL abort_busy got mem_req=%b owner=%b want 1 1", mem_req, owner);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({mem_req, dm_ack, owner, if_ack} !== 4'b0) begin
      fails++; $display("FAIL abort_async got %b want 0000", {mem_req, dm_ack, owner, if_ack});
    end
    dm_req = 0;
    tick; tick;
    reset = 1'b1;
    tick;
    mem_wait = 1; mem_base = 64'h0000_0000_1234_0000;
    sb.push_back('{1'b0, mem_base + 64'h44});
    if_addr = 64'h44; if_req = 1;
    while (!got && cyc < 40) begin
      tick; cyc++;
      if (dm_ack !== 1'b0) bad_dm = 1;
      if (if_ack) got = 1;
    end
    checks++;
    if (!got) begin fails++; $display("FAIL abort_refetch_timeout got no if_ack want ack"); sb.delete(); end
    else begin
      e = sb.pop_front();
      if (if_rdata !== e.data[31:0] || cyc != 3 || bad_dm) begin
        fails++; $display("FAIL abort_refetch got rdata=%h lat=%0d dm_seen=%b want %h 3 0", if_rdata, cyc, bad_dm, e.data[31:0]);
      end
    end
    if_req = 0;
    tick;
  endtask

  task automatic test_idle_ack;
    exp_t        e;
    logic [31:0] if_keep;
    logic [63:0] dm_keep;
    int          cyc = 0;
    bit          got = 0, bad = 0;
    if_keep = if_rdata; dm_keep = dm_rdata;
    mem_auto = 0;
    mem_rdata = 64'h5555_5555_5555_5555; mem_ack = 1;
    tick;
    mem_ack = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick;
      if (if_ack || dm_ack || mem_req) bad = 1;
    end
    checks++;
    if (bad || if_rdata !== if_keep || dm_rdata !== dm_keep) begin
      fails++; $display("FAIL idle_ack got activity=%b if=%h dm=%h want 0 %h %h", bad, if_rdata, dm_rdata, if_keep, dm_keep);
    end
    mem_auto = 1; mem_wait = 0; mem_base = 64'h0000_0000_0000_1000;
    sb.push_back('{1'b0, mem_base + 64'h8});
    if_addr = 64'h8; if_req = 1;
    while (!got && cyc < 40) begin
      tick; cyc++;
      if (if_ack) got = 1;
    end
    checks++;
    if (!got) begin fails++; $display("FAIL idle_followup_timeout got no if_ack want ack"); sb.delete(); end
    else begin
      e = sb.pop_front();
      if (if_rdata !== e.data[31:0] || cyc != 2) begin
        fails++; $display("FAIL idle_followup got rdata=%h lat=%0d want %h 2", if_rdata, cyc, e.data[31:0]);
      end
    end
    if_req = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_dm_store;
    test_if_fetch;
    test_contention;
    test_starve;
    test_reset_abort;
    test_idle_ack;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1);
  end

endmodule
